mole_round_sched: RTL

- Game sequencer for the whack-a-mole LED display.
- Runs three difficulty levels, and in each level pops a fixed number of moles on one of 4 LEDs at a level-dependent pace.
- Judges player button presses against the lit LED and accumulates a score.
- Sits between the board-level start/reset/button inputs and the LED and score display drivers. It owns all game timing.

---
 rtl/mole_pkg.sv | 24 ++
 rtl/mole_lfsr.sv | 31 +++
 rtl/mole_round_sched.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mole_pkg.sv
// rtl/mole_pkg.sv - shared states and constants for the whack-a-mole round sequencer
package mole_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEAD = 3'd1,
        ST_SHOW = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [1:0] LVL_IDLE  = 2'd0;
    localparam logic [1:0] LVL_MAX   = 2'd3;
    localparam logic [5:0] SCORE_MAX = 6'd63;
    localparam logic [3:0] BTN_NONE  = 4'b1111;

    // Right-shift Galois mask for x^8 + x^6 + x^5 + x^4 + 1.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// rtl/mole_lfsr.sv - free-running 8-bit Galois LFSR that picks mole positions
module mole_lfsr
    import mole_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    always_comb begin
        q_d = {1'b0, q_q[7:1]};
        if (q_q[0]) begin
            q_d = q_d ^ LFSR_TAPS;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/mole_round_sched.sv
// rtl/mole_round_sched.sv - whack-a-mole game sequencer: levels, mole timing, press judging, score
module mole_round_sched
    import mole_pkg::*;
#(
    parameter int         TICK_DIV      = 100000000,
    parameter int         L1_PERIOD     = 3,
    parameter int         L2_PERIOD     = 2,
    parameter int         L3_PERIOD     = 1,
    parameter int         MOLES_PER_LVL = 8,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] button,
    output logic [3:0] mole_led,
    output logic [1:0] level,
    output logic [5:0] score,
    output logic       busy,
    output logic       done
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (MOLES_PER_LVL > 1) ? $clog2(MOLES_PER_LVL) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(MOLES_PER_LVL - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]    slot_tick_q, slot_tick_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    level_q, level_d;
    logic [5:0]    score_q, score_d;
    logic [3:0]    mole_led_q, mole_led_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [3:0]    btn_q, btn_d;
    logic [3:0]    btn_prev_q, btn_prev_d;

    logic [7:0] lfsr;
    logic       lfsr_unused;
    logic       running;
    logic       tick;
    logic       slot_end;
    logic       press_evt;
    logic       hit;
    logic [3:0] period_m1;
    logic [6:0] score_sum;

    mole_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .q     (lfsr)
    );

    assign lfsr_unused = ^lfsr[7:2];

    always_comb begin
        case (level_q)
            2'd1:    period_m1 = 4'(L1_PERIOD - 1);
            2'd2:    period_m1 = 4'(L2_PERIOD - 1);
            default: period_m1 = 4'(L3_PERIOD - 1);
        endcase
        running   = state_q inside {ST_LEAD, ST_SHOW, ST_WAIT};
        tick      = running && (tick_cnt_q == TICK_LAST);
        slot_end  = (state_q == ST_SHOW || state_q == ST_WAIT) && tick && (slot_tick_q == period_m1);
        press_evt = (btn_prev_q == BTN_NONE) && (btn_q != BTN_NONE);
        hit       = (~btn_q == mole_led_q);
        score_sum = {1'b0, score_q} + {5'b0, level_q};
    end

    always_comb begin
        state_d     = state_q;
        slot_tick_d = slot_tick_q;
        slot_d      = slot_q;
        level_d     = level_q;
        score_d     = score_q;
        mole_led_d  = mole_led_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        btn_d       = button;
        btn_prev_d  = btn_q;
        tick_cnt_d  = (running && !tick) ? tick_cnt_q + 1'b1 : '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_LEAD;
                    score_d     = '0;
                    level_d     = 2'd1;
                    busy_d      = 1'b1;
                    slot_d      = '0;
                    slot_tick_d = '0;
                    tick_cnt_d  = '0;
                end
            end
            ST_LEAD: begin
                if (tick) begin
                    state_d     = ST_SHOW;
                    slot_d      = '0;
                    slot_tick_d = '0;
                    mole_led_d  = onehot4(lfsr[1:0]);
                end
            end
            ST_SHOW, ST_WAIT: begin
                // Judge the press first so a press on the slot-end edge still scores.
                if (state_q == ST_SHOW && press_evt) begin
                    if (hit) begin
                        score_d = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[5:0];
                    end
                    mole_led_d = '0;
                    state_d    = ST_WAIT;
                end
                if (tick) begin
                    slot_tick_d = slot_tick_q + 1'b1;
                end
                if (slot_end) begin
                    slot_tick_d = '0;
                    if (slot_q < SLOT_LAST) begin
                        slot_d     = slot_q + 1'b1;
                        state_d    = ST_SHOW;
                        mole_led_d = onehot4(lfsr[1:0]);
                    end else if (level_q < LVL_MAX) begin
                        level_d    = level_q + 1'b1;
                        slot_d     = '0;
                        state_d    = ST_SHOW;
                        mole_led_d = onehot4(lfsr[1:0]);
                    end else begin
                        state_d    = ST_DONE;
                        mole_led_d = '0;
                        level_d    = LVL_IDLE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            slot_tick_q <= '0;
            slot_q      <= '0;
            level_q     <= LVL_IDLE;
            score_q     <= '0;
            mole_led_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            btn_q       <= BTN_NONE;
            btn_prev_q  <= BTN_NONE;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            slot_tick_q <= slot_tick_d;
            slot_q      <= slot_d;
            level_q     <= level_d;
            score_q     <= score_d;
            mole_led_q  <= mole_led_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            btn_q       <= btn_d;
            btn_prev_q  <= btn_prev_d;
        end
    end

    assign mole_led = mole_led_q;
    assign level    = level_q;
    assign score    = score_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
